pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage CPU pipeline.
- Detects load-use hazards and arbitrates them against branch/jump redirects and multi-cycle instruction/data memory waits.
- Drives the PC hold and the per-stage pipeline-register hold/reset strobes.
- Tracks wrong-path fetches still in flight when a redirect occurs, and squashes them on return.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive busy cycles after which STALL_TIMEOUT sets.
- CNT_WIDTH, 16: width of the busy-cycle watchdog counter and the optional statistics counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-low reset.
- ID_RS1_ADDR  input  5  rs1 of the instruction in ID.
- ID_RS2_ADDR  input  5  rs2 of the instruction in ID.
- ID_USES_RS1  input  1  ID instruction reads rs1.
- ID_USES_RS2  input  1  ID instruction reads rs2.
- EX_MEM_READ  input  1  the instruction in EX is a load.
- EX_RD_ADDR  input  5  rd of the instruction in EX.
- BJ_SIG  input  1  branch taken or jump resolved in EX.
- IMEM_BUSY  input  1  instruction fetch not yet complete.
- DMEM_BUSY  input  1  data access in MEM not yet complete.
- PC_HOLD  output  1  PC keeps its value.
- PR_IF_ID_HOLD  output  1  IF/ID register holds.
- PR_IF_ID_RESET  output  1  IF/ID register loads a bubble.
- PR_ID_EX_HOLD  output  1  ID/EX register holds.
- PR_ID_EX_RESET  output  1  ID/EX register loads a bubble.
- PR_EX_MEM_HOLD  output  1  EX/MEM register holds.
- PR_MEM_WB_RESET  output  1  MEM/WB register loads a bubble.
- STALL_TIMEOUT  output  1  sticky watchdog flag.

Behaviour:
- Reset (RESET==0 at a CLK edge):
  - state=RUN, watchdog=0, STALL_TIMEOUT=0.
  - While RESET is low: all *_RESET outputs=1, all HOLD outputs=0, PC_HOLD=0.
- Timing: control outputs are combinational from registered state plus current inputs. Zero-cycle latency; the decision applies at the same edge.
- LU hazard: LU = EX_MEM_READ && EX_RD_ADDR!=0 && ((ID_USES_RS1 && ID_RS1_ADDR==EX_RD_ADDR) || (ID_USES_RS2 && ID_RS2_ADDR==EX_RD_ADDR)).
- Per-cycle priority, highest first:
  1. DMEM_BUSY: PC_HOLD, PR_IF_ID_HOLD, PR_ID_EX_HOLD, PR_EX_MEM_HOLD, PR_MEM_WB_RESET all =1. Everything else is suppressed, including BJ_SIG and LU. The branch stays frozen in EX and re-evaluates after the wait.
  2. BJ_SIG: PR_IF_ID_RESET=1, PR_ID_EX_RESET=1, PC_HOLD=0 so the redirect target loads. If IMEM_BUSY is also 1, next state=SQUASH.
  3. LU: PC_HOLD=1, PR_IF_ID_HOLD=1, PR_ID_EX_RESET=1. This lasts exactly one cycle, because the bubble clears LU on the next cycle.
  4. IMEM_BUSY: PC_HOLD=1, PR_IF_ID_RESET=1; downstream stages advance.
  5. Otherwise all outputs are 0.
- States:
  - RUN: normal operation.
  - DMEM_WAIT: entered while DMEM_BUSY is 1; returns to RUN the first cycle DMEM_BUSY=0.
  - IMEM_WAIT: entered while an IMEM_BUSY stall is active (priority 4 wins); returns to RUN the first cycle IMEM_BUSY=0.
  - SQUASH: a wrong-path fetch is in flight.
    - PC_HOLD=0 in the redirect cycle only; PC_HOLD=1 thereafter until the fetch returns.
    - PR_IF_ID_RESET=1 for every cycle while IMEM_BUSY=1, and also in the first cycle IMEM_BUSY=0, so the returning instruction is discarded.
    - Then goes to RUN.
    - DMEM_BUSY during SQUASH overrides outputs per priority 1 but does not leave SQUASH.
    - A new BJ_SIG during SQUASH re-arms SQUASH.
- Simultaneous events:
  - BJ_SIG and LU together: flush wins and PR_IF_ID_HOLD=0. PR_IF_ID_HOLD and PR_IF_ID_RESET are never both 1.
  - DMEM_BUSY and IMEM_BUSY together: DMEM behaviour applies. The IMEM fetch completing meanwhile is not lost, because IF/ID is held and the PC is held.
- Watchdog:
  - Increments each cycle IMEM_BUSY||DMEM_BUSY is 1; clears on a cycle with both 0.
  - Saturates at TIMEOUT_CYCLES; on reaching it STALL_TIMEOUT=1 and stays 1 until reset.
  - Saturating arithmetic; no wrap.
- Reset mid-stall: state returns to RUN immediately; SQUASH tracking is discarded.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs LU_STALL_COUNT, FLUSH_COUNT and MEM_STALL_COUNT, each CNT_WIDTH bits.
  - Each counts cycles in which priority 3, 2 or 1 respectively is active.
  - Saturating; cleared on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - FSM state encoding: RUN=2'd0, DMEM_WAIT=2'd1, IMEM_WAIT=2'd2, SQUASH=2'd3.
  - REG_ADDR_WIDTH=5.
  - Zero-register constant.
- One natural sub-module: hazard_stall_watchdog. It holds the saturating busy counter and the sticky flag, and is reused for each stats counter under HAZARD_STATS_EN.

Test Plan:
1. Load-use: EX load with rd=5, ID with rs1=5 and ID_USES_RS1=1 -> exactly 1 cycle of PC_HOLD=1, PR_IF_ID_HOLD=1, PR_ID_EX_RESET=1. With rd=0 -> no stall.
2. BJ_SIG=1 with LU also true -> PR_IF_ID_RESET=1, PR_ID_EX_RESET=1, PR_IF_ID_HOLD=0, PC_HOLD=0.
3. BJ_SIG while IMEM_BUSY=1 for 3 further cycles -> state SQUASH; PR_IF_ID_RESET=1 for 4 cycles, including the completion cycle; then RUN.
4. DMEM_BUSY for 4 cycles with BJ_SIG=1 -> freeze outputs for 4 cycles with flush suppressed; the flush fires on cycle 5.
5. TIMEOUT_CYCLES=8, DMEM_BUSY held for 10 cycles -> STALL_TIMEOUT rises after the 8th busy cycle and stays 1 after DMEM_BUSY drops; cleared only by RESET=0.
6. RESET=0 asserted in SQUASH -> next cycle state=RUN, PR_*_RESET=1 during reset, counters=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the CPU pipeline sequencer: FSM encoding,
// register-address width and the hard-wired zero register.
package cpu_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    IMEM_WAIT = 2'd2,
    SQUASH    = 2'd3
  } hz_state_e;

  function automatic logic reads_reg(input logic                      uses,
                                     input logic [REG_ADDR_WIDTH-1:0] src,
                                     input logic [REG_ADDR_WIDTH-1:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_watchdog.sv
// Saturating event counter with a sticky flag that sets when the count
// reaches LIMIT. Used as the busy watchdog and as the statistics counters.
module hazard_stall_watchdog #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             flag
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < LIMIT_V)) begin
      count_d = count_q + WIDTH'(1);
    end
    flag_d = flag_q | (count_d == LIMIT_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count = count_q;
  assign flag  = flag_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect and
// memory-wait arbitration. HAZARD_STATS_EN adds saturating event counters.
module pipeline_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RS2_ADDR,
  input  logic                      ID_USES_RS1,
  input  logic                      ID_USES_RS2,
  input  logic                      EX_MEM_READ,
  input  logic [REG_ADDR_WIDTH-1:0] EX_RD_ADDR,
  input  logic                      BJ_SIG,
  input  logic                      IMEM_BUSY,
  input  logic                      DMEM_BUSY,
  output logic                      PC_HOLD,
  output logic                      PR_IF_ID_HOLD,
  output logic                      PR_IF_ID_RESET,
  output logic                      PR_ID_EX_HOLD,
  output logic                      PR_ID_EX_RESET,
  output logic                      PR_EX_MEM_HOLD,
  output logic                      PR_MEM_WB_RESET,
  output logic                      STALL_TIMEOUT
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]      LU_STALL_COUNT,
  output logic [CNT_WIDTH-1:0]      FLUSH_COUNT,
  output logic [CNT_WIDTH-1:0]      MEM_STALL_COUNT
`endif
);

  hz_state_e state_q, state_d;
  logic      lu;
  logic      lu_act, flush_act, mem_act;
  logic      busy;

  assign lu = EX_MEM_READ && (EX_RD_ADDR != ZERO_REG) &&
              (reads_reg(ID_USES_RS1, ID_RS1_ADDR, EX_RD_ADDR) ||
               reads_reg(ID_USES_RS2, ID_RS2_ADDR, EX_RD_ADDR));

  always_comb begin
    state_d         = state_q;
    PC_HOLD         = 1'b0;
    PR_IF_ID_HOLD   = 1'b0;
    PR_IF_ID_RESET  = 1'b0;
    PR_ID_EX_HOLD   = 1'b0;
    PR_ID_EX_RESET  = 1'b0;
    PR_EX_MEM_HOLD  = 1'b0;
    PR_MEM_WB_RESET = 1'b0;
    lu_act          = 1'b0;
    flush_act       = 1'b0;
    mem_act         = 1'b0;

    if (DMEM_BUSY) begin
      mem_act         = 1'b1;
      PC_HOLD         = 1'b1;
      PR_IF_ID_HOLD   = 1'b1;
      PR_ID_EX_HOLD   = 1'b1;
      PR_EX_MEM_HOLD  = 1'b1;
      PR_MEM_WB_RESET = 1'b1;
      state_d         = (state_q == SQUASH) ? SQUASH : DMEM_WAIT;
    end else if (BJ_SIG) begin
      flush_act      = 1'b1;
      PR_IF_ID_RESET = 1'b1;
      PR_ID_EX_RESET = 1'b1;
      state_d        = IMEM_BUSY ? SQUASH : RUN;
    end else if (state_q == SQUASH) begin
      // PC stays on the redirect target until the stale fetch has been
      // dropped, including the cycle it returns in.
      PC_HOLD        = 1'b1;
      PR_IF_ID_RESET = 1'b1;
      state_d        = IMEM_BUSY ? SQUASH : RUN;
    end else if (lu) begin
      lu_act         = 1'b1;
      PC_HOLD        = 1'b1;
      PR_IF_ID_HOLD  = 1'b1;
      PR_ID_EX_RESET = 1'b1;
      state_d        = RUN;
    end else if (IMEM_BUSY) begin
      PC_HOLD        = 1'b1;
      PR_IF_ID_RESET = 1'b1;
      state_d        = IMEM_WAIT;
    end else begin
      state_d = RUN;
    end

    if (!RESET) begin
      state_d         = RUN;
      PC_HOLD         = 1'b0;
      PR_IF_ID_HOLD   = 1'b0;
      PR_IF_ID_RESET  = 1'b1;
      PR_ID_EX_HOLD   = 1'b0;
      PR_ID_EX_RESET  = 1'b1;
      PR_EX_MEM_HOLD  = 1'b0;
      PR_MEM_WB_RESET = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = IMEM_BUSY || DMEM_BUSY;

  logic [CNT_WIDTH-1:0] wd_count_unused;

  hazard_stall_watchdog #(
    .WIDTH (CNT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk   (CLK),
    .rst_n (RESET),
    .inc   (busy),
    .clr   (!busy),
    .count (wd_count_unused),
    .flag  (STALL_TIMEOUT)
  );

`ifdef HAZARD_STATS_EN
  localparam int unsigned STAT_MAX = (2 ** CNT_WIDTH) - 1;
  logic [2:0] stat_sat_unused;

  hazard_stall_watchdog #(.WIDTH(CNT_WIDTH), .LIMIT(STAT_MAX)) u_lu_cnt (
    .clk(CLK), .rst_n(RESET), .inc(lu_act), .clr(1'b0),
    .count(LU_STALL_COUNT), .flag(stat_sat_unused[0])
  );

  hazard_stall_watchdog #(.WIDTH(CNT_WIDTH), .LIMIT(STAT_MAX)) u_flush_cnt (
    .clk(CLK), .rst_n(RESET), .inc(flush_act), .clr(1'b0),
    .count(FLUSH_COUNT), .flag(stat_sat_unused[1])
  );

  hazard_stall_watchdog #(.WIDTH(CNT_WIDTH), .LIMIT(STAT_MAX)) u_mem_cnt (
    .clk(CLK), .rst_n(RESET), .inc(mem_act), .clr(1'b0),
    .count(MEM_STALL_COUNT), .flag(stat_sat_unused[2])
  );
`else
  logic [2:0] stat_act_unused;
  assign stat_act_unused = {lu_act, flush_act, mem_act};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (watchdog
// limit shortened to 8 cycles).
module tb_pipeline_hazard_controller;
  import cpu_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, ex_rd;
  logic       uses1, uses2, ex_load, bj, imem_busy, dmem_busy;
  logic       pc_hold, if_id_hold, if_id_reset, id_ex_hold, id_ex_reset;
  logic       ex_mem_hold, mem_wb_reset, stall_timeout;
  logic [6:0] outs;

`ifdef HAZARD_STATS_EN
  logic [15:0] lu_cnt, flush_cnt, mem_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // {PC, IF/ID hold, IF/ID reset, ID/EX hold, ID/EX reset, EX/MEM hold, MEM/WB reset}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_RST   = 7'b0010101;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_FLUSH = 7'b0010100;
  localparam logic [6:0] O_DMEM  = 7'b1101011;
  localparam logic [6:0] O_IMEM  = 7'b1010000;

  assign outs = {pc_hold, if_id_hold, if_id_reset, id_ex_hold, id_ex_reset,
                 ex_mem_hold, mem_wb_reset};

  pipeline_hazard_controller #(
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (16)
  ) dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .ID_RS1_ADDR     (rs1),
    .ID_RS2_ADDR     (rs2),
    .ID_USES_RS1     (uses1),
    .ID_USES_RS2     (uses2),
    .EX_MEM_READ     (ex_load),
    .EX_RD_ADDR      (ex_rd),
    .BJ_SIG          (bj),
    .IMEM_BUSY       (imem_busy),
    .DMEM_BUSY       (dmem_busy),
    .PC_HOLD         (pc_hold),
    .PR_IF_ID_HOLD   (if_id_hold),
    .PR_IF_ID_RESET  (if_id_reset),
    .PR_ID_EX_HOLD   (id_ex_hold),
    .PR_ID_EX_RESET  (id_ex_reset),
    .PR_EX_MEM_HOLD  (ex_mem_hold),
    .PR_MEM_WB_RESET (mem_wb_reset),
    .STALL_TIMEOUT   (stall_timeout)
`ifdef HAZARD_STATS_EN
    ,
    .LU_STALL_COUNT  (lu_cnt),
    .FLUSH_COUNT     (flush_cnt),
    .MEM_STALL_COUNT (mem_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
    uses1 = 1'b0; uses2 = 1'b0; ex_load = 1'b0;
    bj = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (outs !== O_RST) begin
      errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST);
    end
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout);
    end
    checks++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, RUN);
    end
    checks++;
    if (dut.u_wd.count_q !== 16'd0) begin
      errors++; $display("FAIL reset_wdcount got=%0d exp=0", dut.u_wd.count_q);
    end
    @(negedge clk);
    dmem_busy = 1'b1; bj = 1'b1;
    #1;
    checks++;
    if (outs !== O_RST) begin
      errors++; $display("FAIL reset_overrides_busy got=%b exp=%b", outs, O_RST);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL post_reset_idle got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_load = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; uses1 = 1'b1; rs2 = 5'd3;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL lu_rs1 got=%b exp=%b", outs, O_LU);
    end
    // The bubble now sits in EX, so the load is gone from the comparison
    @(negedge clk);
    ex_load = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL lu_one_cycle got=%b exp=%b", outs, O_IDLE);
    end
    @(negedge clk);
    ex_load = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; uses1 = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL lu_rd_zero got=%b exp=%b", outs, O_IDLE);
    end
    @(negedge clk);
    ex_rd = 5'd7; rs1 = 5'd2; uses1 = 1'b1; rs2 = 5'd7; uses2 = 1'b1;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL lu_rs2 got=%b exp=%b", outs, O_LU);
    end
    @(negedge clk);
    uses2 = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL lu_rs2_unused got=%b exp=%b", outs, O_IDLE);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_bj_lu();
    @(negedge clk);
    ex_load = 1'b1; ex_rd = 5'd9; rs1 = 5'd9; uses1 = 1'b1; bj = 1'b1;
    #1;
    checks++;
    if (outs !== O_FLUSH) begin
      errors++; $display("FAIL bj_beats_lu got=%b exp=%b", outs, O_FLUSH);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL bj_no_squash got=%0d exp=%0d", dut.state_q, RUN);
    end
  endtask

  task automatic test_squash();
    @(negedge clk);
    bj = 1'b1; imem_busy = 1'b1;
    #1;
    checks++;
    if (outs !== O_FLUSH) begin
      errors++; $display("FAIL sq_redirect got=%b exp=%b", outs, O_FLUSH);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bj = 1'b0;
      #1;
      checks++;
      if (dut.state_q !== SQUASH) begin
        errors++; $display("FAIL sq_state[%0d] got=%0d exp=%0d", i, dut.state_q, SQUASH);
      end
      checks++;
      if (outs !== O_IMEM) begin
        errors++; $display("FAIL sq_busy[%0d] got=%b exp=%b", i, outs, O_IMEM);
      end
    end
    @(negedge clk);
    imem_busy = 1'b0;
    #1;
    checks++;
    if ((outs & 7'b0111111) !== 7'b0010000) begin
      errors++; $display("FAIL sq_discard got=%b exp=x010000", outs);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL sq_exit_state got=%0d exp=%0d", dut.state_q, RUN);
    end
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL sq_exit_outs got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  task automatic test_dmem_bj();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_busy = 1'b1; bj = 1'b1;
      imem_busy = (i == 2);
      #1;
      checks++;
      if (outs !== O_DMEM) begin
        errors++; $display("FAIL dmem_freeze[%0d] got=%b exp=%b", i, outs, O_DMEM);
      end
      if (i > 0) begin
        checks++;
        if (dut.state_q !== DMEM_WAIT) begin
          errors++; $display("FAIL dmem_state[%0d] got=%0d exp=%0d", i, dut.state_q, DMEM_WAIT);
        end
      end
    end
    @(negedge clk);
    dmem_busy = 1'b0; imem_busy = 1'b0;
    #1;
    checks++;
    if (outs !== O_FLUSH) begin
      errors++; $display("FAIL dmem_then_flush got=%b exp=%b", outs, O_FLUSH);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      dmem_busy = 1'b1;
      #1;
      checks++;
      if (stall_timeout !== (k >= 9)) begin
        errors++; $display("FAIL timeout_cycle%0d got=%b exp=%b", k, stall_timeout, (k >= 9));
      end
    end
    @(negedge clk);
    dmem_busy = 1'b0;
    #1;
    checks++;
    if (dut.u_wd.count_q !== 16'd8) begin
      errors++; $display("FAIL timeout_saturate got=%0d exp=8", dut.u_wd.count_q);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got=%b exp=1", stall_timeout);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_cleared got=%b exp=0", stall_timeout);
    end
  endtask

  task automatic test_reset_squash();
    @(negedge clk);
    bj = 1'b1; imem_busy = 1'b1;
    @(negedge clk);
    bj = 1'b0;
    #1;
    checks++;
    if (dut.state_q !== SQUASH) begin
      errors++; $display("FAIL rsq_enter got=%0d exp=%0d", dut.state_q, SQUASH);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== O_RST) begin
      errors++; $display("FAIL rsq_outs got=%b exp=%b", outs, O_RST);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL rsq_state got=%0d exp=%0d", dut.state_q, RUN);
    end
    checks++;
    if (dut.u_wd.count_q !== 16'd0) begin
      errors++; $display("FAIL rsq_wdcount got=%0d exp=0", dut.u_wd.count_q);
    end
    rst_n = 1'b1;
    imem_busy = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL rsq_no_discard got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_bj_lu();
    test_squash();
    test_dmem_bj();
    test_timeout();
    test_reset_squash();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
